// File: rtl/stream_sink_pkg.sv
// Shared types and helpers for the stream_sink receive endpoint.
package stream_sink_pkg;

    // Receive FSM states; encoding is visible on the debug state output.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // Widest tdata the checksum helper handles.
    localparam int CSUM_MAX_W = 1024;

    // One checksum step over a w-bit word: rotate left by one, then XOR data.
    // Operands are carried zero-extended to CSUM_MAX_W bits.
    function automatic logic [CSUM_MAX_W-1:0] csum_step(
        input logic [CSUM_MAX_W-1:0] csum,
        input logic [CSUM_MAX_W-1:0] data,
        input int unsigned           w
    );
        logic [CSUM_MAX_W-1:0] mask;
        logic [CSUM_MAX_W-1:0] rot;
        mask = (w >= CSUM_MAX_W) ? '1
                                 : ((CSUM_MAX_W'(1) << w) - CSUM_MAX_W'(1));
        rot  = ((csum << 1) | (csum >> (w - 1))) & mask;
        return rot ^ (data & mask);
    endfunction

endpackage

// File: rtl/stream_ready_gen.sv
// Pseudo-random backpressure source: free-running LFSR plus threshold compare.
module stream_ready_gen
    import stream_sink_pkg::*;
#(
    parameter int          STALL_THRESH = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    output logic ok
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED   = (LFSR_SEED == 16'h0000) ? LFSR_W'(1) : LFSR_SEED;
    localparam logic [7:0]        THRESH = 8'(STALL_THRESH);

    logic [LFSR_W-1:0] lfsr;

    // LFSR advances every cycle after reset, independent of stream traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    // THRESH of 0 makes ok constantly true.
    assign ok = (lfsr[7:0] >= THRESH);

endmodule

// File: rtl/stream_sink.sv
// AXI4-Stream receive endpoint: captures one LENGTH-beat frame into RAM,
// keeps a rotate-XOR checksum and flags tlast framing errors.
//
// Handshake: a beat transfers on a rising edge where s_tvalid & s_tready.
// s_tready is a register driven only from the FSM next state and the
// backpressure generator, never from s_tvalid, and is low outside RECV and
// after the final beat, so no beat beyond LENGTH is ever accepted.
module stream_sink
    import stream_sink_pkg::*;
#(
    parameter int          WIDTH        = 128,
    parameter int          LENGTH       = 768,
    parameter int          STALL_THRESH = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    localparam int         CW           = $clog2(LENGTH + 1),
    localparam int         AW           = $clog2(LENGTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    beat_count,
    output logic [WIDTH-1:0] checksum,
    output logic             err_tlast,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       dbg_state
);

    localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

    state_t state;
    state_t next_state;
    logic   ok;
    logic   xfer;
    logic   last_beat;
    logic   arm;

    logic [WIDTH-1:0] mem [LENGTH];

    stream_ready_gen #(
        .STALL_THRESH (STALL_THRESH),
        .LFSR_SEED    (LFSR_SEED)
    ) u_ready_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .ok    (ok)
    );

    assign xfer      = s_tvalid & s_tready & (state == RECV);
    assign last_beat = (beat_count == LAST_IDX);
    assign arm       = start & (state != RECV);

    // Next-state logic; start is ignored while a frame is in progress.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RECV;
            RECV:    if (xfer && last_beat) next_state = DONE;
            DONE:    if (start) next_state = RECV;
            default: next_state = IDLE;
        endcase
    end

    // State register and registered ready, looking one state ahead.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_tready <= 1'b0;
        end else begin
            state    <= next_state;
            s_tready <= (next_state == RECV) & ok;
        end
    end

    // Per-frame counters: cleared when a frame is armed, stepped per beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_count <= '0;
            checksum   <= '0;
            err_tlast  <= 1'b0;
        end else if (arm) begin
            beat_count <= '0;
            checksum   <= '0;
            err_tlast  <= 1'b0;
        end else if (xfer) begin
            beat_count <= beat_count + CW'(1);
            checksum   <= WIDTH'(csum_step(CSUM_MAX_W'(checksum),
                                           CSUM_MAX_W'(s_tdata), WIDTH));
            if (s_tlast != last_beat) err_tlast <= 1'b1;
        end
    end

    // Capture RAM write port; contents survive re-arming and reset.
    always_ff @(posedge clk) begin
        if (xfer) mem[beat_count[AW-1:0]] <= s_tdata;
    end

    // Registered read port; same-edge write to the same address reads old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    assign busy      = (state == RECV);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: doc/stream_sink.md
# stream_sink

AXI4-Stream receive endpoint: the consuming end of the `data_gen` source protocol. Accepts one frame of `LENGTH` beats, with optional pseudo-random backpressure, and stores every beat in an internal capture RAM. It keeps a running checksum and flags framing errors. It terminates `data_route` output ports in simulation and on-chip self-test, and replaces file-dump monitors with a synthesizable sink.

## Interface
- `WIDTH`, 128, tdata width in bits (≥2)
- `LENGTH`, 768, beats per frame (≥2)
- `STALL_THRESH`, 0, backpressure threshold 0..255; 0 = always ready when receiving
- `LFSR_SEED`, 16'hACE1, backpressure LFSR seed; a value of 0 is replaced by 1
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  single-cycle pulse; arms reception of one frame
- `s_tdata`  in  WIDTH  stream data
- `s_tvalid`  in  1  stream valid
- `s_tlast`  in  1  end of frame marker
- `s_tready`  out  1  stream ready, registered
- `busy`  out  1  state == RECV
- `done`  out  1  state == DONE
- `beat_count`  out  $clog2(LENGTH+1)  beats accepted in the current frame
- `checksum`  out  WIDTH  running rotate-XOR checksum
- `err_tlast`  out  1  sticky; tlast seen on the wrong beat, or missing on the last beat
- `rd_addr`  in  $clog2(LENGTH)  capture RAM read address
- `rd_data`  out  WIDTH  capture RAM data, 1-cycle read latency

## Operation
- States:
  - IDLE: `start` → RECV.
  - RECV: accepting the final beat (beat index LENGTH-1) → DONE.
  - DONE: `start` → RECV.
- `start` while in RECV is ignored.
- Entering RECV from `start` clears `beat_count`, `checksum` and `err_tlast`. RAM contents are kept.
- Transfer occurs when `s_tvalid & s_tready` at a rising edge. On each transfer:
  - RAM[beat_count] ← s_tdata
  - beat_count += 1
  - checksum ← {checksum[WIDTH-2:0], checksum[WIDTH-1]} ^ s_tdata
- tlast check on each accepted beat: `err_tlast` sets if `s_tlast` != (beat index == LENGTH-1). The frame still completes after exactly LENGTH beats, regardless of tlast.
- Backpressure uses a 16-bit Fibonacci LFSR, taps 16,14,13,11, which advances every cycle after reset.
  - Ready condition: `ok = (lfsr[7:0] >= STALL_THRESH)`.
  - `s_tready` ← (next_state == RECV) & ok.
- Data is never dropped or reordered. `s_tready` never depends combinationally on `s_tvalid`.

## Timing
- Reset values:
  - state IDLE; `s_tready` 0, `busy` 0, `done` 0, `beat_count` 0, `checksum` 0, `err_tlast` 0.
  - LFSR = seed.
  - `rd_data` 0 until its first read.
- `start` at edge N:
  - `busy`=1 after edge N.
  - `s_tready` may be 1 from edge N onward; with STALL_THRESH=0 it is 1 after edge N.
- Final-beat transfer at edge M:
  - After edge M: `done`=1, `busy`=0, `s_tready`=0, `beat_count`=LENGTH.
  - No beat beyond LENGTH is ever accepted.
- With STALL_THRESH=0 and `s_tvalid` held high, throughput is 1 beat/cycle and a frame takes LENGTH cycles.
- In DONE, `s_tvalid` high is held off indefinitely; the counters are stable.
- Readback: `rd_data` reflects RAM[rd_addr] one cycle after `rd_addr` is applied. A read of the same address as a same-edge write returns the old data.
- `rst_n` low mid-frame: at the next edge, all outputs return to their reset values and the partial frame is abandoned. The source must resend from beat 0.

## Structure
- Shared package `stream_sink_pkg` holds:
  - state enum (IDLE, RECV, DONE)
  - LFSR width and tap constant
  - checksum rotate-XOR function, shared with the Python reference model
- Sub-module `stream_ready_gen`: LFSR plus threshold comparator, with parameters STALL_THRESH and LFSR_SEED and output `ok`. It is reused by other bench sinks.
- The capture RAM is inferred as simple dual-port block RAM.

## Test plan
All scenarios use WIDTH=128 and LENGTH=4 unless stated.
- **Clean frame:** STALL_THRESH=0; `start`, then beats 1,2,3,4 with tlast on beat 4 → `done`=1, `beat_count`=4, `checksum`=0x2, `err_tlast`=0. Reading rd_addr 0..3 returns 1,2,3,4, each one cycle after its address.
- **Bad tlast:** tlast on beat 2 and not on beat 4 → `err_tlast`=1, all 4 beats are captured, `done`=1.
- **Random backpressure:** STALL_THRESH=128 with random `s_tvalid`, LENGTH=768 → `s_tready` is low on roughly 50% of cycles, all 768 beats are captured in order, and `checksum` matches the Python model.
- **Overrun hold-off:** `s_tvalid` stays high with data 5 after the frame → `s_tready`=0, `beat_count` stays 4, RAM[0] stays 1.
- **Reset mid-frame:** `rst_n` low after 2 beats → all outputs return to reset values. A new `start` plus 4 beats completes normally with `checksum`=0x2.
- **Start in RECV:** a `start` pulse after beat 1 is ignored → `beat_count` continues to 4 and `checksum`=0x2.
